// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: shares one block-wide memory port between I-cache refill, D-cache refill
// and D-cache write-back, returning each completed block with a one-cycle pulse.
module mem_refill_arbiter #(
   parameter int ADDR_WIDTH   = 64,
   parameter int BLOCK_WIDTH  = 512,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                   i_clk,
   input  logic                   i_arst,
   input  logic                   i_icache_req,
   input  logic [ADDR_WIDTH-1:0]  i_icache_addr,
   input  logic                   i_dcache_rd_req,
   input  logic [ADDR_WIDTH-1:0]  i_dcache_rd_addr,
   input  logic                   i_dcache_wb_req,
   input  logic [ADDR_WIDTH-1:0]  i_dcache_wb_addr,
   input  logic [BLOCK_WIDTH-1:0] i_dcache_wb_block,
   output logic                   o_mem_req,
   output logic                   o_mem_we,
   output logic [ADDR_WIDTH-1:0]  o_mem_addr,
   output logic [BLOCK_WIDTH-1:0] o_mem_wdata,
   input  logic                   i_mem_done,
   input  logic [BLOCK_WIDTH-1:0] i_mem_rdata,
   output logic [BLOCK_WIDTH-1:0] o_fill_block,
   output logic                   o_icache_fill,
   output logic                   o_dcache_fill,
   output logic                   o_dcache_wb_done,
   output logic                   o_busy
);
   localparam int OFS = $clog2(BLOCK_WIDTH / 8);
   localparam int CW  = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WB, RESP} state_t;
   typedef enum logic [1:0] {SRC_I, SRC_D, SRC_WB} src_t;

   state_t                 state_q, state_d;
   src_t                   src_q, src_d;
   logic [CW-1:0]          starve_q, starve_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d, fill_q, fill_d;
   logic                   starved, d_any;

   assign starved = starve_q == CW'(STARVE_LIMIT);
   assign d_any   = i_dcache_wb_req | i_dcache_rd_req;

   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst) begin
         state_q  <= IDLE;
         src_q    <= SRC_I;
         starve_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         fill_q   <= '0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         fill_q   <= fill_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      starve_d = starve_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      fill_d   = fill_q;
      case (state_q)
         IDLE: begin
            if (!i_icache_req) starve_d = '0;
            // I-side wins when it is alone or has already waited out STARVE_LIMIT D grants
            if (i_icache_req && (starved || !d_any)) begin
               state_d  = I_RD;
               src_d    = SRC_I;
               addr_d   = i_icache_addr;
               starve_d = '0;
            end else if (i_dcache_wb_req) begin
               state_d = D_WB;
               src_d   = SRC_WB;
               addr_d  = i_dcache_wb_addr;
               wdata_d = i_dcache_wb_block;
               if (i_icache_req) starve_d = starve_q + CW'(1);
            end else if (i_dcache_rd_req) begin
               state_d = D_RD;
               src_d   = SRC_D;
               addr_d  = i_dcache_rd_addr;
               if (i_icache_req) starve_d = starve_q + CW'(1);
            end
         end
         I_RD, D_RD: begin
            if (i_mem_done) begin
               fill_d  = i_mem_rdata;
               state_d = RESP;
            end
         end
         D_WB: state_d = i_mem_done ? RESP : D_WB;
         default: state_d = IDLE;
      endcase
   end

   assign o_mem_req        = (state_q == I_RD) | (state_q == D_RD) | (state_q == D_WB);
   assign o_mem_we         = state_q == D_WB;
   assign o_mem_addr       = {addr_q[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
   assign o_mem_wdata      = wdata_q;
   assign o_fill_block     = fill_q;
   assign o_icache_fill    = (state_q == RESP) & (src_q == SRC_I);
   assign o_dcache_fill    = (state_q == RESP) & (src_q == SRC_D);
   assign o_dcache_wb_done = (state_q == RESP) & (src_q == SRC_WB);
   assign o_busy           = state_q != IDLE;
endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb_mem_refill_arbiter: directed corner cases, then randomized request mixes checked by a
// transaction-level arbitration model feeding expected-transaction and expected-response queues.
module tb_mem_refill_arbiter;
   localparam int AW = 64;
   localparam int BW = 512;
   localparam int STARVE = 4;

   logic          i_clk = 0;
   logic          i_arst;
   logic          i_icache_req, i_dcache_rd_req, i_dcache_wb_req, i_mem_done;
   logic [AW-1:0] i_icache_addr, i_dcache_rd_addr, i_dcache_wb_addr;
   logic [BW-1:0] i_dcache_wb_block, i_mem_rdata;
   logic          o_mem_req, o_mem_we, o_icache_fill, o_dcache_fill, o_dcache_wb_done, o_busy;
   logic [AW-1:0] o_mem_addr;
   logic [BW-1:0] o_mem_wdata, o_fill_block;

   mem_refill_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .STARVE_LIMIT(STARVE)) dut (
      .i_clk(i_clk), .i_arst(i_arst),
      .i_icache_req(i_icache_req), .i_icache_addr(i_icache_addr),
      .i_dcache_rd_req(i_dcache_rd_req), .i_dcache_rd_addr(i_dcache_rd_addr),
      .i_dcache_wb_req(i_dcache_wb_req), .i_dcache_wb_addr(i_dcache_wb_addr),
      .i_dcache_wb_block(i_dcache_wb_block),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .i_mem_done(i_mem_done), .i_mem_rdata(i_mem_rdata),
      .o_fill_block(o_fill_block), .o_icache_fill(o_icache_fill), .o_dcache_fill(o_dcache_fill),
      .o_dcache_wb_done(o_dcache_wb_done), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int            kind;   // 0 = I refill, 1 = D refill, 2 = D write-back
      logic [AW-1:0] addr;
      logic [BW-1:0] data;
   } txn_t;

   txn_t          exp_q[$];
   txn_t          resp_q[$];
   int            vectors = 0;
   int            errs = 0;
   bit            sb_en = 0;
   logic [AW-1:0] i_a[8], r_a[8], w_a[8];
   logic [BW-1:0] w_d[8];
   int            ni_g = 0, nr_g = 0, nw_g = 0;
   int            ii = 0, ri = 0, wi = 0;
   bit            prev_req = 0, waiting = 0;
   int            cd = 0, cur_kind = 0;
   logic [BW-1:0] pat_a, pat_b;

   task automatic check(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] rand512();
      logic [BW-1:0] v;
      for (int k = 0; k < BW / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [AW-1:0] align(logic [AW-1:0] a);
      return a & ~64'h3F;
   endfunction

   // Grant order from the arbitration rules, applied one grant at a time to pending counts
   function automatic void plan(int nw, int nr, int ni);
      int w = 0, r = 0, i = 0, cnt = 0, k;
      bit ip;
      while (w < nw || r < nr || i < ni) begin
         ip = i < ni;
         if (!ip) cnt = 0;
         if (ip && (cnt == STARVE || (w == nw && r == nr))) k = 0;
         else k = (w < nw) ? 2 : 1;
         if (k == 0) cnt = 0;
         else if (ip) cnt = cnt + 1;
         case (k)
            0: begin exp_q.push_back('{0, align(i_a[i]), '0}); i++; end
            1: begin exp_q.push_back('{1, align(r_a[r]), '0}); r++; end
            default: begin exp_q.push_back('{2, align(w_a[w]), w_d[w]}); w++; end
         endcase
      end
   endfunction

   // Requester agents: on a pulse, present the next queued miss or drop the request
   always @(negedge i_clk) if (sb_en) begin
      if (o_icache_fill) begin
         ii++;
         if (ii < ni_g) i_icache_addr = i_a[ii]; else i_icache_req = 0;
      end
      if (o_dcache_fill) begin
         ri++;
         if (ri < nr_g) i_dcache_rd_addr = r_a[ri]; else i_dcache_rd_req = 0;
      end
      if (o_dcache_wb_done) begin
         wi++;
         if (wi < nw_g) begin
            i_dcache_wb_addr = w_a[wi];
            i_dcache_wb_block = w_d[wi];
         end else i_dcache_wb_req = 0;
      end
   end

   // Memory responder: checks each new transaction, answers after a random delay,
   // and throws spurious done pulses while no transaction is active
   always @(negedge i_clk) if (sb_en) begin
      txn_t t;
      logic [BW-1:0] rd;
      i_mem_done = 0;
      if (o_mem_req && !prev_req) begin
         if (exp_q.size() == 0) begin
            vectors++; errs++;
            $display("FAIL unexpected_txn: got addr %0h, expected no transaction", o_mem_addr);
            cur_kind = 1;
         end else begin
            t = exp_q.pop_front();
            check("txn_addr", o_mem_addr, t.addr);
            check("txn_we", o_mem_we, t.kind == 2);
            if (t.kind == 2) check("txn_wdata", o_mem_wdata, t.data);
            cur_kind = t.kind;
         end
         waiting = 1;
         cd = $urandom_range(0, 4);
      end
      if (o_mem_req && waiting) begin
         if (cd == 0) begin
            rd = rand512();
            i_mem_done = 1;
            i_mem_rdata = rd;
            resp_q.push_back('{cur_kind, '0, rd});
            waiting = 0;
         end else cd--;
      end else if (!o_mem_req && $urandom_range(0, 3) == 0) begin
         i_mem_done = 1;
         i_mem_rdata = rand512();
      end
      prev_req = o_mem_req;
   end

   // Response monitor
   always @(negedge i_clk) if (sb_en) begin
      txn_t r;
      int kind_act;
      if (o_icache_fill || o_dcache_fill || o_dcache_wb_done) begin
         check("pulse_onehot", 2'(o_icache_fill) + 2'(o_dcache_fill) + 2'(o_dcache_wb_done), 1);
         kind_act = o_icache_fill ? 0 : o_dcache_fill ? 1 : 2;
         if (resp_q.size() == 0) begin
            vectors++; errs++;
            $display("FAIL unexpected_pulse: got kind %0d, expected no pulse", kind_act);
         end else begin
            r = resp_q.pop_front();
            check("resp_kind", kind_act, r.kind);
            if (r.kind != 2) check("fill_block", o_fill_block, r.data);
         end
      end
   end

   task automatic run(int nw, int nr, int ni);
      int cyc = 0;
      for (int k = 0; k < nw; k++) begin w_a[k] = {$urandom, $urandom}; w_d[k] = rand512(); end
      for (int k = 0; k < nr; k++) r_a[k] = {$urandom, $urandom};
      for (int k = 0; k < ni; k++) i_a[k] = {$urandom, $urandom};
      plan(nw, nr, ni);
      wi = 0; ri = 0; ii = 0;
      nw_g = nw; nr_g = nr; ni_g = ni;
      i_dcache_wb_req = nw > 0;
      i_dcache_wb_addr = w_a[0];
      i_dcache_wb_block = w_d[0];
      i_dcache_rd_req = nr > 0;
      i_dcache_rd_addr = r_a[0];
      i_icache_req = ni > 0;
      i_icache_addr = i_a[0];
      while ((wi < nw || ri < nr || ii < ni || o_busy) && cyc < 3000) begin
         @(negedge i_clk);
         cyc++;
      end
      if (cyc >= 3000) begin
         vectors++; errs++;
         $display("FAIL scenario_timeout: got %0d/%0d/%0d done, expected %0d/%0d/%0d", wi, ri, ii, nw, nr, ni);
      end
      repeat ($urandom_range(1, 3)) @(negedge i_clk);
   endtask

   initial begin
      i_arst = 0; i_mem_done = 0; i_mem_rdata = '0;
      i_dcache_rd_req = 0; i_dcache_rd_addr = '0;
      i_dcache_wb_req = 0; i_dcache_wb_addr = '0; i_dcache_wb_block = '0;
      i_icache_req = 1; i_icache_addr = 64'h1047;
      repeat (2) @(negedge i_clk);
      check("rst_mem_req", o_mem_req, 0);
      check("rst_mem_we", o_mem_we, 0);
      check("rst_mem_addr", o_mem_addr, 0);
      check("rst_mem_wdata", o_mem_wdata, 0);
      check("rst_fill_block", o_fill_block, 0);
      check("rst_pulses", {o_icache_fill, o_dcache_fill, o_dcache_wb_done}, 0);
      check("rst_busy", o_busy, 0);
      i_arst = 1;
      @(negedge i_clk);
      check("t1_mem_req", o_mem_req, 1);
      check("t1_mem_addr", o_mem_addr, 64'h1040);
      check("t1_mem_we", o_mem_we, 0);
      repeat (4) @(negedge i_clk);
      check("t2_req_held", o_mem_req, 1);
      pat_a = rand512();
      i_mem_done = 1; i_mem_rdata = pat_a;
      @(negedge i_clk);
      i_mem_done = 0;
      check("t2_icache_fill", o_icache_fill, 1);
      check("t2_fill_block", o_fill_block, pat_a);
      check("t2_mem_req_drop", o_mem_req, 0);
      i_icache_req = 0;
      @(negedge i_clk);
      check("t2_busy_drop", o_busy, 0);
      check("t2_fill_once", o_icache_fill, 0);
      i_mem_done = 1; i_mem_rdata = rand512();
      @(negedge i_clk);
      i_mem_done = 0;
      check("t6_busy", o_busy, 0);
      check("t6_pulses", {o_icache_fill, o_dcache_fill, o_dcache_wb_done}, 0);
      i_dcache_rd_req = 1; i_dcache_rd_addr = 64'h2233;
      @(negedge i_clk);
      check("t5_mem_req", o_mem_req, 1);
      check("t5_mem_addr", o_mem_addr, 64'h2200);
      #2 i_arst = 0;
      #1 check("t5_rst_mem_req", o_mem_req, 0);
      check("t5_rst_busy", o_busy, 0);
      @(negedge i_clk);
      i_mem_done = 1;
      @(negedge i_clk);
      i_mem_done = 0;
      check("t5_no_fill", o_dcache_fill, 0);
      i_arst = 1;
      @(negedge i_clk);
      check("t5_regrant", o_mem_req, 1);
      check("t5_regrant_addr", o_mem_addr, 64'h2200);
      check("t5_regrant_we", o_mem_we, 0);
      pat_b = rand512();
      i_mem_done = 1; i_mem_rdata = pat_b;
      @(negedge i_clk);
      i_mem_done = 0;
      check("t5_dcache_fill", o_dcache_fill, 1);
      check("t5_fill_block", o_fill_block, pat_b);
      i_dcache_rd_req = 0;
      @(negedge i_clk);
      check("t5_busy_drop", o_busy, 0);
      sb_en = 1;
      @(negedge i_clk);
      run(1, 1, 1);
      run(0, 6, 1);
      run(3, 5, 2);
      for (int s = 0; s < 40; s++) begin
         int nw, nr, ni;
         nw = $urandom_range(0, 3);
         nr = $urandom_range(0, 4);
         ni = $urandom_range(0, 2);
         if (nw + nr + ni == 0) nr = 1;
         run(nw, nr, ni);
      end
      check("exp_q_drained", exp_q.size(), 0);
      check("resp_q_drained", resp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
